// File: rtl/rat_ckpt_pkg.sv
// Shared sizing and state encoding for the RAT checkpoint block.
package rat_ckpt_pkg;

    localparam int NUM_CKPT   = 8;
    localparam int NUM_AREG   = 32;
    localparam int PTAG_W     = 6;
    localparam int MAP_W      = NUM_AREG * PTAG_W;
    localparam int CKPT_IDX_W = $clog2(NUM_CKPT);
    localparam int DROP_W     = 8;

    // One architectural-to-physical map, reg k in element k.
    typedef logic [NUM_AREG-1:0][PTAG_W-1:0] map_t;

    localparam int STATE_W = 1;
    localparam logic [STATE_W-1:0] ST_IDLE    = 1'b0;
    localparam logic [STATE_W-1:0] ST_RESTORE = 1'b1;

endpackage

// File: rtl/rat_ckpt_mem.sv
// Checkpoint storage: NUM_CKPT map slots with per-slot valid bits.
// One write port, one combinational read port, and a clear-all of the
// valid bits. Clear wins over a same-cycle write.
module rat_ckpt_mem
    import rat_ckpt_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [CKPT_IDX_W-1:0] wr_idx,
    input  logic [MAP_W-1:0]      wr_data,
    input  logic                  clr_all,
    input  logic [CKPT_IDX_W-1:0] rd_idx,
    output logic [MAP_W-1:0]      rd_data,
    output logic                  rd_vld
);

    map_t                slot_q [NUM_CKPT];
    logic [NUM_CKPT-1:0] vld_q;

    // Map payload needs no reset: it is only read when its valid bit is set.
    for (genvar g = 0; g < NUM_CKPT; g++) begin : g_slot
        always_ff @(posedge clk) begin
            if (wr_en && wr_idx == CKPT_IDX_W'(g))
                slot_q[g] <= wr_data;
        end
    end

    // Valid bits: set on write, all dropped on clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vld_q <= '0;
        else if (clr_all)
            vld_q <= '0;
        else if (wr_en)
            vld_q[wr_idx] <= 1'b1;
    end

    assign rd_data = slot_q[rd_idx];
    assign rd_vld  = vld_q[rd_idx];

endmodule

// File: rtl/rat_checkpoint.sv
// Branch checkpoint store for the register alias table. Copies snapshot
// the live RAT into a slot; a paste restores one slot through a
// valid/ready handshake and invalidates every checkpoint.
module rat_checkpoint
    import rat_ckpt_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Copy_RAT,
    input  logic [CKPT_IDX_W-1:0] tail_num,
    input  logic                  Paste_RAT,
    input  logic [CKPT_IDX_W-1:0] head_num,
    input  logic [MAP_W-1:0]      rat_in,
    output logic                  restore_valid,
    input  logic                  restore_ready,
    output logic [MAP_W-1:0]      restore_map,
    output logic                  restore_err,
    output logic                  busy,
    output logic [DROP_W-1:0]     drop_cnt
);

    logic [STATE_W-1:0]    state;
    logic                  prev_copy;
    logic                  prev_paste;
    logic [CKPT_IDX_W-1:0] prev_tail;

    logic                  copy_acc;
    logic                  paste_acc;
    logic                  in_idle;
    logic                  mem_wr;
    logic                  mem_clr;
    logic                  drop_evt;
    logic [MAP_W-1:0]      rd_data;
    logic                  rd_vld;

    // Request qualification. A held Copy_RAT snapshots again whenever the
    // tail moves; a held Paste_RAT only fires once.
    always_comb begin
        copy_acc  = Copy_RAT && (!prev_copy || tail_num != prev_tail);
        paste_acc = Paste_RAT && !prev_paste;
        in_idle   = (state == ST_IDLE);
        mem_clr   = in_idle && paste_acc;
        mem_wr    = in_idle && copy_acc && !paste_acc;
        drop_evt  = copy_acc && (!in_idle || paste_acc);
    end

    rat_ckpt_mem u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (mem_wr),
        .wr_idx  (tail_num),
        .wr_data (rat_in),
        .clr_all (mem_clr),
        .rd_idx  (head_num),
        .rd_data (rd_data),
        .rd_vld  (rd_vld)
    );

    // Previous-cycle copies of the request inputs for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_copy  <= 1'b0;
            prev_paste <= 1'b0;
            prev_tail  <= '0;
        end else begin
            prev_copy  <= Copy_RAT;
            prev_paste <= Paste_RAT;
            prev_tail  <= tail_num;
        end
    end

    // Restore FSM: the slot is read before the same-edge clear takes effect,
    // and restore_valid/map are held until the consumer accepts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            restore_valid <= 1'b0;
            restore_map   <= '0;
            restore_err   <= 1'b0;
        end else begin
            restore_err <= 1'b0;
            if (state == ST_RESTORE) begin
                if (restore_valid && restore_ready) begin
                    restore_valid <= 1'b0;
                    state         <= ST_IDLE;
                end
            end else if (paste_acc) begin
                if (rd_vld) begin
                    restore_map   <= rd_data;
                    restore_valid <= 1'b1;
                    state         <= ST_RESTORE;
                end else begin
                    restore_err <= 1'b1;
                end
            end
        end
    end

    // Saturating count of snapshots lost to a paste or an active restore.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            drop_cnt <= '0;
        else if (drop_evt && drop_cnt != {DROP_W{1'b1}})
            drop_cnt <= drop_cnt + 1'b1;
    end

    assign busy = (state == ST_RESTORE);

endmodule

// File: tb/tb_rat_checkpoint.sv
// Self-checking bench for rat_checkpoint: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_rat_checkpoint;

    logic         clk = 1'b0;
    logic         rst;
    logic         Copy_RAT, Paste_RAT, restore_ready;
    logic [2:0]   tail_num, head_num;
    logic [191:0] rat_in;
    logic         restore_valid, restore_err, busy;
    logic [191:0] restore_map;
    logic [7:0]   drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: slot contents, slot validity, whether a restored
    // map is outstanding, and the previous request inputs.
    logic [191:0] m_slot [8];
    bit           m_vld  [8];
    bit           m_hold;
    logic [191:0] m_map;
    bit           m_err;
    int           m_drop;
    bit           p_copy, p_paste;
    logic [2:0]   p_tail;

    logic [191:0] A, B, C, D, E, F, G;

    rat_checkpoint dut (
        .clk           (clk),
        .rst           (rst),
        .Copy_RAT      (Copy_RAT),
        .tail_num      (tail_num),
        .Paste_RAT     (Paste_RAT),
        .head_num      (head_num),
        .rat_in        (rat_in),
        .restore_valid (restore_valid),
        .restore_ready (restore_ready),
        .restore_map   (restore_map),
        .restore_err   (restore_err),
        .busy          (busy),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: run exceeded time budget");
        $fatal(1);
    end

    task automatic cmp(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [191:0] rand_map();
        logic [191:0] m;
        for (int k = 0; k < 6; k++) m[32*k +: 32] = $urandom;
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_vld[i] = 0;
        m_hold = 0; m_map = '0; m_err = 0; m_drop = 0;
        p_copy = 0; p_paste = 0; p_tail = '0;
    endtask

    task automatic bump_drop();
        if (m_drop < 255) m_drop++;
    endtask

    // One rising edge of the model, from the inputs presented at that edge.
    task automatic model_step();
        bit new_copy, new_paste;
        new_copy  = Copy_RAT && (!p_copy || tail_num != p_tail);
        new_paste = Paste_RAT && !p_paste;
        m_err = 0;
        if (m_hold) begin
            if (new_copy) bump_drop();
            if (restore_ready) m_hold = 0;
        end else if (new_paste) begin
            if (new_copy) bump_drop();
            if (m_vld[head_num]) begin
                m_map  = m_slot[head_num];
                m_hold = 1;
            end else begin
                m_err = 1;
            end
            for (int i = 0; i < 8; i++) m_vld[i] = 0;
        end else if (new_copy) begin
            m_slot[tail_num] = rat_in;
            m_vld[tail_num]  = 1;
        end
        p_copy  = Copy_RAT;
        p_paste = Paste_RAT;
        p_tail  = tail_num;
    endtask

    task automatic check_all();
        cmp("restore_valid", 192'(restore_valid), 192'(m_hold));
        cmp("busy", 192'(busy), 192'(m_hold));
        cmp("restore_err", 192'(restore_err), 192'(m_err));
        cmp("drop_cnt", 192'(drop_cnt), 192'(m_drop));
        if (m_hold) cmp("restore_map", restore_map, m_map);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic drive(input bit c, input logic [2:0] t, input bit p,
                         input logic [2:0] h, input logic [191:0] r, input bit rdy);
        Copy_RAT = c; tail_num = t; Paste_RAT = p; head_num = h;
        rat_in = r; restore_ready = rdy;
    endtask

    // Asynchronous reset between edges; outputs must clear at once.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        cmp("rst_map", restore_map, '0);
        cmp("rst_busy", 192'(busy), '0);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        A = rand_map(); B = rand_map(); C = rand_map(); D = rand_map();
        E = rand_map(); F = rand_map(); G = rand_map();
        drive(0, 0, 0, 0, '0, 1);
        rst = 1'b1;
        #2;
        model_reset();
        check_all();
        cmp("reset_map", restore_map, '0);
        cmp("reset_drop", 192'(drop_cnt), '0);
        rst = 1'b0;

        // Single copy to slot 2, then restore it.
        drive(1, 2, 0, 0, A, 1); tick();
        drive(0, 2, 1, 2, B, 1); tick();
        cmp("t33_valid", 192'(restore_valid), 192'(1));
        cmp("t33_map", restore_map, A);
        drive(0, 2, 0, 2, B, 1); tick();
        cmp("t33_idle", 192'(busy), '0);

        // Held copy walking the tail, then held on slot 2 with new data.
        for (int rep = 0; rep < 2; rep++) begin
            drive(1, 0, 0, 0, A, 1); tick();
            drive(1, 1, 0, 0, B, 1); tick();
            drive(1, 2, 0, 0, C, 1); tick();
            drive(1, 2, 0, 0, D, 1); tick();
            tick();
            drive(0, 2, 1, (rep == 0) ? 3'd1 : 3'd2, D, 1); tick();
            cmp("t34_map", restore_map, (rep == 0) ? B : C);
            drive(0, 2, 0, 0, D, 1); tick();
        end

        // Paste to a slot never written.
        drive(0, 0, 1, 5, '0, 1); tick();
        cmp("t35_err", 192'(restore_err), 192'(1));
        cmp("t35_valid", 192'(restore_valid), '0);
        drive(0, 0, 0, 5, '0, 1); tick();
        cmp("t35_err_pulse", 192'(restore_err), '0);
        drive(0, 0, 1, 2, '0, 1); tick();
        cmp("t35_cleared", 192'(restore_err), 192'(1));
        drive(0, 0, 0, 2, '0, 1); tick();

        // Back-pressured restore with a copy dropped meanwhile.
        drive(1, 3, 0, 0, E, 0); tick();
        drive(0, 3, 1, 3, A, 0); tick();
        drive(0, 3, 0, 3, A, 0); tick();
        drive(1, 0, 0, 3, A, 0); tick();
        drive(0, 0, 0, 3, A, 0); tick();
        tick();
        cmp("t36_drop", 192'(drop_cnt), 192'(1));
        cmp("t36_map", restore_map, E);
        cmp("t36_busy", 192'(busy), 192'(1));
        drive(0, 0, 0, 3, A, 1); tick();
        cmp("t36_idle", 192'(busy), '0);

        // Copy and paste together, then reset mid-restore.
        drive(1, 4, 0, 0, F, 0); tick();
        drive(0, 4, 0, 0, F, 0); tick();
        drive(1, 6, 1, 4, A, 0); tick();
        cmp("t37_map", restore_map, F);
        cmp("t37_drop", 192'(drop_cnt), 192'(2));
        drive(0, 6, 0, 4, A, 0); tick();
        do_reset();
        cmp("t37_rst_valid", 192'(restore_valid), '0);

        // Drop counter saturation during a long stalled restore.
        drive(1, 0, 0, 0, G, 0); tick();
        drive(0, 0, 1, 0, G, 0); tick();
        for (int i = 0; i < 600; i++) begin
            drive(i[0], 0, 0, 0, G, 0); tick();
        end
        cmp("sat_drop", 192'(drop_cnt), 192'(255));
        drive(0, 0, 0, 0, G, 1); tick();
        do_reset();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) == 0) ? 3'($urandom) : tail_num,
                  ($urandom_range(0, 4) == 0),
                  3'($urandom),
                  rand_map(),
                  ($urandom_range(0, 2) != 0));
            tick();
            if ($urandom_range(0, 400) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
